// File: rtl/led_meter_sequencer.sv
// led_meter_sequencer: APA102 frame sequencer drawing one decaying-peak bar graph per audio channel.
// Ports:
//   clk_12mhz     system clock
//   rst           asynchronous active-high reset
//   sample_clk    sample strobe, peaks update on its synchronised rising edge
//   sample_in     N_CH signed W-bit samples, channel c at [c*W +: W]
//   apa102_busy   driver busy, no command is issued while high
//   apa102_cmd    00 NONE, 01 SOF, 10 PIXEL, 11 EOF (held between issues)
//   apa102_strobe one-cycle command issue
//   pixel_*       pixel colour, updated with each PIXEL issue
//   frame_done    one-cycle pulse with the EOF issue
// Build option: define LED_METER_PEAK_HOLD_EN to add a per-channel white peak-hold marker.
module led_meter_sequencer #(
    parameter int         W           = 16,
    parameter int         N_CH        = 4,
    parameter int         PX_PER_CH   = 16,
    parameter int         DECAY_SHIFT = 10,
    parameter logic [7:0] BRIGHT      = 8'd255,
    parameter int         FRAME_GAP   = 1200,
    parameter int         HOLD_FRAMES = 32
) (
    input  logic            clk_12mhz,
    input  logic            rst,
    input  logic            sample_clk,
    input  logic [N_CH*W-1:0] sample_in,
    input  logic            apa102_busy,
    output logic [1:0]      apa102_cmd,
    output logic            apa102_strobe,
    output logic [7:0]      pixel_red,
    output logic [7:0]      pixel_green,
    output logic [7:0]      pixel_blue,
    output logic            frame_done
);
    localparam int LP = $clog2(PX_PER_CH);
    localparam int LS = W - 1 - LP;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int GW = $clog2(FRAME_GAP + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SOF   = 3'd1;
    localparam logic [2:0] S_PIXEL = 3'd2;
    localparam logic [2:0] S_EOF   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [LP-1:0] RED_IDX = LP'(3 * PX_PER_CH / 4);
    localparam logic [W-2:0]  A_MAX   = '1;

    logic [2:0]        state;
    logic [CW-1:0]     ch;
    logic [LP-1:0]     idx;
    logic [GW-1:0]     gap;
    logic [2:0]        sc_q;
    logic              rise, iss, sof_iss;
    logic [N_CH*LP-1:0] lvl_all;
    logic [N_CH-1:0]   nz_all;
    logic [LP-1:0]     cur_lvl;
    logic              cur_nz, lit, hot, white;
    logic [7:0]        px_r, px_g, px_b;

    // two flops synchronise sample_clk, the third gives the previous level for edge detection
    always_ff @(posedge clk_12mhz or posedge rst)
        if (rst) sc_q <= '0;
        else     sc_q <= {sc_q[1:0], sample_clk};

    assign rise    = sc_q[1] & ~sc_q[2];
    assign iss     = !apa102_busy && !apa102_strobe;
    assign sof_iss = (state == S_SOF) && iss;

`ifdef LED_METER_PEAK_HOLD_EN
    localparam int TW = $clog2(HOLD_FRAMES + 1);
    logic [N_CH*LP-1:0] hold_all;
    logic [LP-1:0]      cur_hold;
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic signed [W-1:0] x;
        logic [W-1:0]        nx;
        logic [W-2:0]        a, peak;
        logic [LP-1:0]       lvl_n, lvl;
        logic                nz;
        assign x  = sample_in[c*W +: W];
        assign nx = -x;
        // negating the most negative sample wraps back to itself; clamp it to the largest magnitude
        assign a  = x[W-1] ? (nx[W-1] ? A_MAX : nx[W-2:0]) : x[W-2:0];
        assign lvl_n = LP'(peak >> LS);
        always_ff @(posedge clk_12mhz or posedge rst)
            if (rst)       peak <= '0;
            else if (rise) peak <= (a > peak) ? a : peak - (peak >> DECAY_SHIFT);
        // the snapshot keeps a frame consistent while peaks keep moving
        always_ff @(posedge clk_12mhz or posedge rst)
            if (rst) begin
                lvl <= '0;
                nz  <= 1'b0;
            end else if (sof_iss) begin
                lvl <= lvl_n;
                nz  <= peak != '0;
            end
        assign lvl_all[c*LP +: LP] = lvl;
        assign nz_all[c]           = nz;
`ifdef LED_METER_PEAK_HOLD_EN
        logic [LP-1:0] hold;
        logic [TW-1:0] tmr;
        always_ff @(posedge clk_12mhz or posedge rst)
            if (rst) begin
                hold <= '0;
                tmr  <= '0;
            end else if (sof_iss) begin
                if (lvl_n >= hold) begin
                    hold <= lvl_n;
                    tmr  <= TW'(HOLD_FRAMES);
                end else if (tmr == '0) hold <= lvl_n;
                else                    tmr  <= tmr - 1'b1;
            end
        assign hold_all[c*LP +: LP] = hold;
`endif
    end

    assign cur_lvl = lvl_all[ch*LP +: LP];
    assign cur_nz  = nz_all[ch];
    assign lit     = (idx <= cur_lvl) && cur_nz;
    assign hot     = idx >= RED_IDX;
`ifdef LED_METER_PEAK_HOLD_EN
    assign cur_hold = hold_all[ch*LP +: LP];
    assign white    = (idx == cur_hold) && ((cur_hold > cur_lvl) || cur_nz);
`else
    assign white    = 1'b0;
`endif
    assign px_r = (white || (lit && hot))  ? BRIGHT : 8'd0;
    assign px_g = (white || (lit && !hot)) ? BRIGHT : 8'd0;
    assign px_b = white ? BRIGHT : 8'd0;

    always_ff @(posedge clk_12mhz or posedge rst)
        if (rst) begin
            state         <= S_IDLE;
            apa102_strobe <= 1'b0;
            apa102_cmd    <= 2'b00;
            pixel_red     <= '0;
            pixel_green   <= '0;
            pixel_blue    <= '0;
            frame_done    <= 1'b0;
            ch            <= '0;
            idx           <= '0;
            gap           <= '0;
        end else begin
            apa102_strobe <= 1'b0;
            frame_done    <= 1'b0;
            case (state)
                S_IDLE: state <= S_SOF;
                S_SOF: if (iss) begin
                    apa102_strobe <= 1'b1;
                    apa102_cmd    <= 2'b01;
                    ch            <= '0;
                    idx           <= '0;
                    state         <= S_PIXEL;
                end
                S_PIXEL: if (iss) begin
                    apa102_strobe <= 1'b1;
                    apa102_cmd    <= 2'b10;
                    pixel_red     <= px_r;
                    pixel_green   <= px_g;
                    pixel_blue    <= px_b;
                    if (idx == LP'(PX_PER_CH - 1)) begin
                        idx <= '0;
                        if (ch == CW'(N_CH - 1)) state <= S_EOF;
                        else                     ch    <= ch + 1'b1;
                    end else idx <= idx + 1'b1;
                end
                S_EOF: if (iss) begin
                    apa102_strobe <= 1'b1;
                    apa102_cmd    <= 2'b11;
                    frame_done    <= 1'b1;
                    gap           <= '0;
                    state         <= S_GAP;
                end
                S_GAP: if (gap == GW'(FRAME_GAP - 1)) state <= S_SOF;
                       else                           gap   <= gap + 1'b1;
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_led_meter_sequencer.sv
// tb_led_meter_sequencer: randomized check of frame sequencing and bar rendering against a peak/level model.
module tb_led_meter_sequencer;
    localparam int PX = 16;
    localparam int NC = 4;
    localparam int PIX = NC * PX;
    localparam int FRAME_GAP = 1200;
    localparam int HOLD = 32;

    logic        clk_12mhz = 1'b0;
    logic        rst = 1'b1;
    logic        sample_clk = 1'b0;
    logic [63:0] sample_in = '0;
    logic        apa102_busy = 1'b0;
    logic [1:0]  apa102_cmd;
    logic        apa102_strobe;
    logic [7:0]  pixel_red, pixel_green, pixel_blue;
    logic        frame_done;

    int checks = 0, failures = 0;
    int mpeak[NC];
    int slvl[NC], shold[NC], stmr[NC];
    bit snz[NC];
    int pos = 0, frames = 0, cyc = 0, eof_cyc = 0, stb_cnt = 0, busy_cnt = 0;
    bit have_eof = 0, busy_seen = 0, busy_mode = 0, busy_force = 0, prev_stb = 0, busy_q = 0;

    led_meter_sequencer dut (
        .clk_12mhz(clk_12mhz), .rst(rst), .sample_clk(sample_clk), .sample_in(sample_in),
        .apa102_busy(apa102_busy), .apa102_cmd(apa102_cmd), .apa102_strobe(apa102_strobe),
        .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue),
        .frame_done(frame_done)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_px(input int c, input int i);
        bit lit = (i <= slvl[c]) && snz[c];
        bit white = 0;
`ifdef LED_METER_PEAK_HOLD_EN
        white = (i == shold[c]) && ((shold[c] > slvl[c]) || snz[c]);
`endif
        if (white) return 'hFFFFFF;
        if (!lit)  return 0;
        return (i >= 3 * PX / 4) ? 'hFF0000 : 'h00FF00;
    endfunction

    always @(posedge clk_12mhz) busy_q <= apa102_busy;

    always @(negedge clk_12mhz) begin
        if (rst) begin
            pos = 0; have_eof = 0; prev_stb = 0; busy_cnt = 0;
            for (int c = 0; c < NC; c++) begin shold[c] = 0; stmr[c] = 0; end
            apa102_busy = busy_force;
        end else begin
            cyc++;
            if (apa102_strobe) begin
                check("busy_ok", busy_q, 0);
                check("stb_len", prev_stb, 0);
                check("frame_done", frame_done, pos == PIX + 1);
                if (pos == 0) begin
                    check("cmd_sof", apa102_cmd, 1);
                    if (have_eof && !busy_seen) check("gap", cyc - eof_cyc, FRAME_GAP + 1);
                    for (int c = 0; c < NC; c++) begin
                        slvl[c] = mpeak[c] >> 11;
                        snz[c]  = mpeak[c] != 0;
                        if (slvl[c] >= shold[c]) begin shold[c] = slvl[c]; stmr[c] = HOLD; end
                        else if (stmr[c] == 0) shold[c] = slvl[c];
                        else stmr[c]--;
                    end
                    stb_cnt = 1; pos = 1;
                end else if (pos <= PIX) begin
                    check("cmd_px", apa102_cmd, 2);
                    check($sformatf("px_c%0d_i%0d", (pos - 1) / PX, (pos - 1) % PX),
                          {pixel_red, pixel_green, pixel_blue}, exp_px((pos - 1) / PX, (pos - 1) % PX));
                    pos++; stb_cnt++;
                end else begin
                    check("cmd_eof", apa102_cmd, 3);
                    stb_cnt++;
                    check("stb_per_frame", stb_cnt, PIX + 2);
                    pos = 0; frames++; eof_cyc = cyc; have_eof = 1; busy_seen = 0;
                end
                if (busy_mode) busy_cnt = 50;
            end
            prev_stb = apa102_strobe;
            apa102_busy = busy_force || busy_cnt > 0;
            if (busy_cnt > 0) busy_cnt--;
            if (apa102_busy) busy_seen = 1;
        end
    end

    task automatic wait_frames(input int n);
        int target = frames + n;
        for (int k = 0; k < n * 6000 && frames < target; k++) @(negedge clk_12mhz);
        if (frames < target) check("frame_timeout", frames, target);
    endtask

    task automatic pulse(input logic [63:0] v);
        sample_in = v;
        sample_clk = 1'b1;
        repeat (2) @(negedge clk_12mhz);
        sample_clk = 1'b0;
        repeat (2) @(negedge clk_12mhz);
        for (int c = 0; c < NC; c++) begin
            int x = $signed(v[c*16 +: 16]);
            int a = (x < 0) ? ((x == -32768) ? 32767 : -x) : x;
            mpeak[c] = (a > mpeak[c]) ? a : mpeak[c] - (mpeak[c] >> 10);
        end
    endtask

    // samples are applied with the driver held busy so no snapshot can land mid-update
    task automatic burst(input logic [63:0] v, input int n);
        busy_force = 1;
        repeat (2) @(negedge clk_12mhz);
        for (int k = 0; k < n; k++) pulse(v);
        repeat (4) @(negedge clk_12mhz);
        busy_force = 0;
    endtask

    function automatic logic [63:0] rnd_sample();
        logic [63:0] v = '0;
        for (int c = 0; c < NC; c++) begin
            int m = $urandom_range(0, 3);
            logic [15:0] s = 16'($urandom);
            v[c*16 +: 16] = (m == 0) ? 16'd0 : (m == 1) ? s :
                            (m == 2) ? (s[0] ? 16'h8000 : 16'h7FFF) : {{8{s[15]}}, s[7:0]};
        end
        return v;
    endfunction

    initial begin
        repeat (3) @(negedge clk_12mhz);
        check("rst_out", {apa102_strobe, apa102_cmd, pixel_red, pixel_green, pixel_blue, frame_done}, 0);
        rst = 1'b0;
        wait_frames(2);
        busy_mode = 1;
        wait_frames(2);
        busy_mode = 0;
        wait_frames(1);
        burst(64'h0000_0000_0000_4000, 41);
        wait_frames(2);
        burst(64'h0000_8000_0000_0000, 1);
        wait_frames(2);
        burst(64'h0, 1024);
        wait_frames(2);
        burst(64'h0000_0000_6064_0000, 1);
        wait_frames(2);
        burst(64'h0, 200);
        wait_frames(2);
        for (int r = 0; r < 6; r++) begin
            busy_force = 1;
            repeat (2) @(negedge clk_12mhz);
            for (int k = $urandom_range(1, 20); k > 0; k--) pulse(rnd_sample());
            repeat (4) @(negedge clk_12mhz);
            busy_force = 0;
            wait_frames($urandom_range(1, 2));
        end
        burst(64'h0000_0000_7530_0000, 1);
        wait_frames(1);
        for (int k = 0; k < 5000 && pos < 21; k++) @(negedge clk_12mhz);
        check("reach_px20", pos, 21);
        #2 rst = 1'b1;
        #1 check("rst_mid", {apa102_strobe, apa102_cmd, pixel_red, pixel_green, pixel_blue, frame_done}, 0);
        for (int c = 0; c < NC; c++) mpeak[c] = 0;
        repeat (2) @(negedge clk_12mhz);
        rst = 1'b0;
        wait_frames(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
